// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: program counter, next-PC selection with delayed-branch
// semantics, instruction-window legality check and the IF/ID pipeline register.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] jr_addr,
    input  logic [31:0] im_data,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        fetch_err_d,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] LAST_PC = RESET_PC + (32'(IM_WORDS) << 2) - 32'd4;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] npc;
    logic        fetch_legal;

    // Branch and jump targets are relative to the instruction sitting in D;
    // F is already on the delay slot, so the redirect lands one fetch later.
    assign pc_plus4      = pc_f + 32'd4;
    assign branch_target = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign jump_target   = {pc_d[31:28], instr_d[25:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            SEL_SEQ:    npc = pc_plus4;
            SEL_BRANCH: npc = branch_target;
            SEL_JUMP:   npc = jump_target;
            SEL_JR:     npc = jr_addr;
            default:    npc = pc_plus4;
        endcase
    end

    assign fetch_legal = (pc_f[1:0] == 2'b00) && (pc_f >= RESET_PC) && (pc_f <= LAST_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            instr_d     <= 32'h0;
            pc_d        <= RESET_PC;
            fetch_err_d <= 1'b0;
            fetch_cnt   <= 32'h0;
        end else if (!stall) begin
            pc_f        <= npc;
            pc_d        <= pc_f;
            // Out-of-window fetches become a nop tagged with the error flag.
            instr_d     <= fetch_legal ? im_data : 32'h0;
            fetch_err_d <= !fetch_legal;
            fetch_cnt   <= fetch_cnt + 32'd1;
        end
    end

    assign pc8_d = pc_d + 32'd8;

endmodule
